// File: rtl/button_press_classifier_if.sv
// ---------------------------------------------------------------------------
// button_press_classifier_if
// Key-pin bundle between the board keys / control logic and the classifier.
//   in            raw asynchronous key inputs, one bit per lane
//   repeat_en     per-lane auto-repeat enable
//   pressed       debounced level, 1 = held
//   short_press   1-cycle pulse on release of a short press
//   long_press    1-cycle pulse when the hold reaches the long threshold
//   repeat_press  1-cycle auto-repeat pulse while a long press is held
// master = key/control side (drives in, repeat_en), slave = classifier.
// ---------------------------------------------------------------------------
interface button_press_classifier_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] in;
  logic [CHANNELS-1:0] repeat_en;
  logic [CHANNELS-1:0] pressed;
  logic [CHANNELS-1:0] short_press;
  logic [CHANNELS-1:0] long_press;
  logic [CHANNELS-1:0] repeat_press;

  modport master (
    output in, repeat_en,
    input  pressed, short_press, long_press, repeat_press
  );

  modport slave (
    input  in, repeat_en,
    output pressed, short_press, long_press, repeat_press
  );
endinterface

// File: rtl/button_press_classifier.sv
// ---------------------------------------------------------------------------
// button_press_classifier
// Multi-lane push-button front end. Each lane: 2-FF synchroniser, polarity
// normalise, debouncer, then a classifier FSM that emits one-cycle
// short / long / auto-repeat strobes. Lanes are fully independent.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    button_press_classifier_if.slave (in, repeat_en -> pressed,
//          short_press, long_press, repeat_press)
// All outputs are registered.
// ---------------------------------------------------------------------------

// One key lane.
//   key        raw asynchronous key pin
//   repeat_en  auto-repeat enable, used directly (synchronous control input)
//   pressed    debounced level
//   short_press / long_press / repeat_press  one-cycle event strobes
module button_lane #(
  parameter int DEB_CYC    = 1,
  parameter int LONG_CYC   = 1,
  parameter int REP_CYC    = 1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  input  logic repeat_en,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic repeat_press
);
  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int HOLD_W = $clog2(LONG_CYC + 1);
  localparam int REP_W  = $clog2(REP_CYC + 1);

  // Raw level of a released key; the synchroniser is preloaded with it so
  // reset never looks like a press edge.
  localparam logic REL_LVL = ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

  // ---------------- synchroniser + debouncer ----------------
  logic             sync1, sync2;
  logic             lvl;
  logic [DEB_W-1:0] deb_cnt;

  assign lvl = sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= REL_LVL;
      sync2   <= REL_LVL;
      pressed <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if (lvl != pressed) begin
        // DEB_CYC-th consecutive disagreement flips the level
        if (deb_cnt == DEB_W'(DEB_CYC - 1)) begin
          pressed <= lvl;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // ---------------- classifier FSM ----------------
  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              short_d, long_d, repeat_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      rep_q        <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      rep_q        <= rep_d;
      short_press  <= short_d;
      long_press   <= long_d;
      repeat_press <= repeat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    rep_d    = rep_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          hold_d = HOLD_W'(1);
          // A one-cycle long threshold is already met on entry.
          if (LONG_CYC <= 1) begin
            state_d = LONG;
            long_d  = 1'b1;
            rep_d   = '0;
          end else begin
            state_d = SHORT;
          end
        end
      end
      SHORT: begin
        // Release is checked first so it wins over reaching LONG_CYC.
        if (!pressed) begin
          state_d = IDLE;
          short_d = 1'b1;
          hold_d  = '0;
        end else if (hold_q >= HOLD_W'(LONG_CYC - 1)) begin
          state_d = LONG;
          long_d  = 1'b1;
          hold_d  = HOLD_W'(LONG_CYC);
          rep_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      LONG: begin
        if (!pressed) begin
          state_d = IDLE;
          hold_d  = '0;
          rep_d   = '0;
        end else if (!repeat_en) begin
          // Disabled repeat parks the interval counter, so re-enabling
          // always gives a full interval before the next pulse.
          rep_d = '0;
        end else if (rep_q == REP_W'(REP_CYC - 1)) begin
          repeat_d = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end
endmodule

module button_press_classifier #(
  parameter int CHANNELS      = 4,
  parameter int CLK_PERIOD_ns = 20,
  parameter int DEBOUNCE_ns   = 5_000_000,
  parameter int LONG_ns       = 500_000_000,
  parameter int REPEAT_ns     = 100_000_000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  button_press_classifier_if.slave    bus
);
  // Cycle counts, floored at 1 so tiny times still behave sanely.
  localparam int DEB_RAW  = DEBOUNCE_ns / CLK_PERIOD_ns;
  localparam int LONG_RAW = LONG_ns / CLK_PERIOD_ns;
  localparam int REP_RAW  = REPEAT_ns / CLK_PERIOD_ns;
  localparam int DEB_CYC  = (DEB_RAW  < 1) ? 1 : DEB_RAW;
  localparam int LONG_CYC = (LONG_RAW < 1) ? 1 : LONG_RAW;
  localparam int REP_CYC  = (REP_RAW  < 1) ? 1 : REP_RAW;

  logic [CHANNELS-1:0] pressed_w;
  logic [CHANNELS-1:0] short_w;
  logic [CHANNELS-1:0] long_w;
  logic [CHANNELS-1:0] repeat_w;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    button_lane #(
      .DEB_CYC    (DEB_CYC),
      .LONG_CYC   (LONG_CYC),
      .REP_CYC    (REP_CYC),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .key          (bus.in[g]),
      .repeat_en    (bus.repeat_en[g]),
      .pressed      (pressed_w[g]),
      .short_press  (short_w[g]),
      .long_press   (long_w[g]),
      .repeat_press (repeat_w[g])
    );
  end

  assign bus.pressed      = pressed_w;
  assign bus.short_press  = short_w;
  assign bus.long_press   = long_w;
  assign bus.repeat_press = repeat_w;
endmodule

// File: tb/tb_button_press_classifier.sv
// ---------------------------------------------------------------------------
// tb_button_press_classifier
// Directed scenarios followed by a random key/enable/reset phase, every
// cycle compared against a timestamp-based behavioural model of the lane
// rules (debounce run length, hold time since the debounced rise, repeat
// interval counting).
// ---------------------------------------------------------------------------
module tb_button_press_classifier;
  localparam int CH  = 2;
  localparam int DEB = 5;
  localparam int LNG = 20;
  localparam int REP = 10;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  button_press_classifier_if #(.CHANNELS(CH)) bus();

  button_press_classifier #(
    .CHANNELS(CH), .CLK_PERIOD_ns(20), .DEBOUNCE_ns(100),
    .LONG_ns(400), .REPEAT_ns(200), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int t     = 0;

  // model state, per channel
  int  dl1 [CH], dl2 [CH];   // two-cycle delay of the normalised key
  int  mp [CH];              // debounced level
  int  run [CH];             // consecutive disagreeing cycles
  int  rise_t [CH];          // cycle the debounced level rose
  bit  tracking [CH];        // a press is being classified
  bit  long_act [CH];        // long press already reported
  int  rep_run [CH];         // enabled cycles since long / last repeat
  logic [CH-1:0] e_p, e_s, e_l, e_r;

  // observed pulse counters, cleared per scenario
  int n_short [CH], n_long [CH], n_rep [CH], n_held [CH];

  task automatic check(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < CH; c++) begin
      n_short[c] = 0; n_long[c] = 0; n_rep[c] = 0; n_held[c] = 0;
    end
  endtask

  task automatic model_step(input logic r, input logic [CH-1:0] k, input logic [CH-1:0] en);
    for (int c = 0; c < CH; c++) begin
      int din;
      e_s[c] = 1'b0; e_l[c] = 1'b0; e_r[c] = 1'b0;
      if (r) begin
        dl1[c] = 0; dl2[c] = 0; mp[c] = 0; run[c] = 0;
        tracking[c] = 0; long_act[c] = 0; rep_run[c] = 0;
      end else begin
        din = dl2[c];
        dl2[c] = dl1[c];
        dl1[c] = (k[c] == 1'b0) ? 1 : 0;
        // events, judged on the level held before this edge
        if (mp[c] == 1 && tracking[c]) begin
          if (!long_act[c] && (t - rise_t[c]) == LNG) begin
            e_l[c] = 1'b1; long_act[c] = 1; rep_run[c] = 0;
          end else if (long_act[c]) begin
            if (en[c]) begin
              rep_run[c]++;
              if (rep_run[c] == REP) begin e_r[c] = 1'b1; rep_run[c] = 0; end
            end else rep_run[c] = 0;
          end
        end else if (mp[c] == 0 && tracking[c]) begin
          if (!long_act[c]) e_s[c] = 1'b1;
          tracking[c] = 0; long_act[c] = 0;
        end
        // debounce
        if (din != mp[c]) begin
          run[c]++;
          if (run[c] == DEB) begin
            mp[c] = 1 - mp[c]; run[c] = 0;
            if (mp[c] == 1) begin rise_t[c] = t; tracking[c] = 1; end
          end
        end else run[c] = 0;
      end
      e_p[c] = (mp[c] == 1);
    end
  endtask

  task automatic tick();
    logic r;
    logic [CH-1:0] k, en;
    r = reset; k = bus.in; en = bus.repeat_en;
    @(posedge clk);
    t++;
    model_step(r, k, en);
    #1;
    check("pressed", bus.pressed, e_p);
    check("short_press", bus.short_press, e_s);
    check("long_press", bus.long_press, e_l);
    check("repeat_press", bus.repeat_press, e_r);
    for (int c = 0; c < CH; c++) begin
      n_short[c] += int'(bus.short_press[c]);
      n_long[c]  += int'(bus.long_press[c]);
      n_rep[c]   += int'(bus.repeat_press[c]);
      n_held[c]  += int'(bus.pressed[c]);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  int dur [CH];
  int sel;

  initial begin
    reset = 1'b1;
    bus.in = 2'b11;
    bus.repeat_en = 2'b00;
    #1;
    // reset then idle
    hold(3);
    reset = 1'b0;
    clear_counts();
    hold(50);
    check_int("idle_held0", n_held[0] + n_held[1], 0);

    // short press on channel 0
    clear_counts();
    bus.in[0] = 1'b0; hold(10);
    bus.in[0] = 1'b1; hold(30);
    check_int("short_cnt0", n_short[0], 1);
    check_int("short_long0", n_long[0], 0);
    check_int("short_ch1_quiet", n_held[1] + n_short[1], 0);

    // bounce never reaches pressed
    clear_counts();
    repeat (5) begin
      bus.in[0] = 1'b0; hold(3);
      bus.in[0] = 1'b1; hold(1);
    end
    hold(20);
    check_int("bounce_held", n_held[0], 0);
    check_int("bounce_pulses", n_short[0] + n_long[0] + n_rep[0], 0);

    // long press with repeat on channel 1
    clear_counts();
    bus.repeat_en[1] = 1'b1;
    bus.in[1] = 1'b0; hold(60);
    bus.in[1] = 1'b1; hold(30);
    check_int("long_cnt1", n_long[1], 1);
    check_int("long_noshort1", n_short[1], 0);
    check_int("long_rep_ge2", int'(n_rep[1] >= 2), 1);

    // long press, repeat disabled, then enabled mid-hold
    clear_counts();
    bus.repeat_en[1] = 1'b0;
    bus.in[1] = 1'b0; hold(60);
    bus.in[1] = 1'b1; hold(30);
    check_int("norep_long1", n_long[1], 1);
    check_int("norep_rep1", n_rep[1], 0);
    bus.in[1] = 1'b0; hold(35);
    bus.repeat_en[1] = 1'b1; hold(25);
    bus.in[1] = 1'b1; hold(30);

    // both pressed, reset mid-hold
    clear_counts();
    bus.in = 2'b00; hold(15);
    reset = 1'b1; hold(1);
    reset = 1'b0; hold(40);
    bus.in = 2'b11; hold(30);
    check_int("rst_noshort", n_short[0] + n_short[1], 0);
    check_int("rst_relong", n_long[0] + n_long[1], 2);

    // random phase
    for (int c = 0; c < CH; c++) dur[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (dur[c] == 0) begin
          bus.in[c] = ~bus.in[c];
          sel = $urandom_range(0, 2);
          dur[c] = (sel == 0) ? $urandom_range(1, 6) :
                   (sel == 1) ? $urandom_range(7, 25) : $urandom_range(26, 70);
        end
        dur[c]--;
        if ($urandom_range(0, 39) == 0) bus.repeat_en[c] = ~bus.repeat_en[c];
      end
      reset = ($urandom_range(0, 399) == 0);
      tick();
    end
    reset = 1'b0;
    bus.in = 2'b11;
    hold(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_press_classifier.md
# button_press_classifier

Multi-channel push-button front end that synchronises, debounces and classifies raw key inputs into a debounced level plus one-cycle short-press, long-press and auto-repeat event pulses. It generalises single-channel long-press detection to CHANNELS independent lanes, with configurable input polarity and per-channel auto-repeat mode. It sits directly behind the board key pins and feeds one-cycle strobes to the control FSMs.

## Interface
- CHANNELS, 4, number of independent key lanes (1..32)
- CLK_PERIOD_ns, 20, clk period
- DEBOUNCE_ns, 5_000_000, required stability time before the debounced level changes
- LONG_ns, 500_000_000, hold time that classifies a press as long
- REPEAT_ns, 100_000_000, auto-repeat interval after long press
- ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = reads 1 when pressed
- Derived: DEB_CYC = max(1, DEBOUNCE_ns/CLK_PERIOD_ns); LONG_CYC = max(1, LONG_ns/CLK_PERIOD_ns); REP_CYC = max(1, REPEAT_ns/CLK_PERIOD_ns); each counter is $clog2(max+1) bits wide
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in  in  CHANNELS  raw asynchronous key inputs
- repeat_en  in  CHANNELS  per-channel auto-repeat enable, sampled every cycle
- pressed  out  CHANNELS  debounced level, 1 = held
- short_press  out  CHANNELS  1-cycle pulse on release of a short press
- long_press  out  CHANNELS  1-cycle pulse when hold reaches LONG_CYC
- repeat_press  out  CHANNELS  1-cycle pulse every REP_CYC cycles after long_press while held and enabled

## Operation
- Per channel: 2-FF synchroniser -> polarity normalise (XOR ACTIVE_LOW) -> debouncer -> classifier FSM. Lanes share no state.
- Debouncer: deb_cnt counts consecutive cycles with normalised sync != pressed. Any cycle of agreement clears deb_cnt. When deb_cnt == DEB_CYC-1 and still differing, pressed toggles and deb_cnt clears. Glitches shorter than DEB_CYC never reach pressed.
- Classifier states: IDLE, SHORT, LONG.
  - IDLE: pressed rises -> SHORT, hold_cnt <= 1.
  - SHORT: hold_cnt increments each cycle pressed = 1. When hold_cnt == LONG_CYC -> LONG, assert long_press, rep_cnt <= 0. If pressed falls first -> IDLE, assert short_press.
  - LONG: while pressed = 1 and repeat_en = 1, rep_cnt increments; at rep_cnt == REP_CYC assert repeat_press and clear rep_cnt. repeat_en = 0 holds rep_cnt at 0. Pressed falls -> IDLE, no pulse.
- hold_cnt saturates at LONG_CYC; rep_cnt wraps only through the explicit clear. No counter overflow is possible.
- Simultaneous events: release on the same cycle hold_cnt would reach LONG_CYC classifies as short (the release wins). repeat_en dropping on a repeat-due cycle suppresses that pulse.
- Event pulses are mutually exclusive per channel per cycle.

## Timing
- Reset: all outputs 0; synchroniser flops and pressed load the released level (normalised 0); all counters 0; FSM IDLE.
- Reset asserted mid-press: outputs drop to 0 on the next edge. After release, a still-held key is re-debounced and treated as a fresh press. No short_press is emitted for the aborted press.
- Raw clean press at edge k: pressed = 1 from edge k+2+DEB_CYC. Release has symmetric latency.
- long_press: high for exactly the one cycle that is LONG_CYC cycles after pressed rises.
- short_press: registered, high for the one cycle after the first edge where pressed = 0.
- First repeat_press: REP_CYC cycles after long_press, then every REP_CYC cycles.
- All outputs are registered; there are no combinational paths from in or repeat_en to outputs.

## Test plan
Use CHANNELS=2, CLK_PERIOD_ns=20, DEBOUNCE_ns=100 (DEB_CYC=5), LONG_ns=400 (LONG_CYC=20), REPEAT_ns=200 (REP_CYC=10), ACTIVE_LOW=1.
- Reset then idle with in=2'b11 -> all outputs 0 for 50 cycles.
- in[0]=0 held 10 cycles then 1 -> pressed[0] rises at cycle 7; one short_press[0] pulse after release; no long_press; channel 1 stays silent.
- in[0] bounce: 0 for 3 cycles, 1 for 1 cycle, repeated 5 times, then 1 -> pressed[0] never asserts; no pulses.
- in[1]=0 held 60 cycles, repeat_en[1]=1 -> long_press[1] at 20 cycles after pressed rises; repeat_press[1] at +10 and +20 after that; no short_press on release.
- Same stimulus with repeat_en[1]=0 -> a single long_press[1] only. Toggling repeat_en[1] to 1 mid-hold -> first repeat comes 10 cycles later.
- Both channels pressed together and reset pulsed mid-hold -> outputs 0 the next cycle; keys still held re-debounce (5+2 cycles) and classify afresh; no spurious short_press.
